// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bundle between the control unit and alu_seq.
//
// Handshake: start is a request that the ALU samples on a rising edge only
// while busy=0; op/ac/bus are captured on that same edge. A start seen while
// busy=1 is dropped, not queued. done is a one-cycle pulse marking that
// result/flags (and mul_hi for MUL) were updated on the preceding edge; busy
// is already low in that cycle, so a new start may be presented there.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] bus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] mul_hi;
    logic [3:0]       flags;      // {V,C,N,Z}
    logic [1:0]       fsm_state;  // debug view of the sequencing FSM

    modport master (
        output start, op, ac, bus,
        input  busy, done, result, mul_hi, flags, fsm_state
    );

    modport slave (
        input  start, op, ac, bus,
        output busy, done, result, mul_hi, flags, fsm_state
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/add/shift ops and an
// iterative shift-add multiplier (one multiplier bit per cycle, LSB first).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   io
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_CLR  = 4'b0000;
    localparam logic [3:0] OP_PASS = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_INC  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // multiplier, shifted right each MUL step
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      step;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   mul_hi_q;
    logic [3:0]         flags_q;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   ex_res;
    logic               ex_c;
    logic               ex_v;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nxt;

    // Signed overflow of a + y: operands agree in sign, result does not.
    function automatic logic ovf(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] r);
        return (a[M] == y[M]) && (r[M] != a[M]);
    endfunction

    // Single-cycle datapath on the latched operands.
    always_comb begin
        sum_ext = '0;
        ex_res  = '0;
        ex_c    = 1'b0;
        ex_v    = 1'b0;
        case (op_q)
            OP_CLR:  ex_res = '0;
            OP_PASS: ex_res = b_q;
            OP_ADD: begin
                sum_ext = {1'b0, a_q} + {1'b0, b_q};
                ex_res  = sum_ext[M:0];
                ex_c    = sum_ext[WIDTH];
                ex_v    = ovf(a_q, b_q, sum_ext[M:0]);
            end
            OP_INC: begin
                sum_ext = {1'b0, a_q} + (WIDTH+1)'(1);
                ex_res  = sum_ext[M:0];
                ex_c    = sum_ext[WIDTH];
                ex_v    = ovf(a_q, WIDTH'(1), sum_ext[M:0]);
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1: 1 means no borrow.
                sum_ext = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
                ex_res  = sum_ext[M:0];
                ex_c    = sum_ext[WIDTH];
                ex_v    = ovf(a_q, ~b_q, sum_ext[M:0]);
            end
            OP_AND:  ex_res = a_q & b_q;
            OP_XOR:  ex_res = a_q ^ b_q;
            OP_OR:   ex_res = a_q | b_q;
            OP_NOT:  ex_res = ~a_q;
            OP_SHL: begin
                ex_res = {a_q[M-1:0], 1'b0};
                ex_c   = a_q[M];
            end
            OP_SHR: begin
                ex_res = {1'b0, a_q[M:1]};
                ex_c   = a_q[0];
            end
            default: ex_res = '0;   // undefined codes behave as CLR
        endcase
    end

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        prod_nxt = {mul_sum, prod[M:1]};
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod     <= '0;
            step     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            mul_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        op_q   <= io.op;
                        a_q    <= io.ac;
                        b_q    <= io.bus;
                        prod   <= '0;
                        step   <= '0;
                        busy_q <= 1'b1;
                        state  <= (io.op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    result_q <= ex_res;
                    flags_q  <= {ex_v, ex_c, ex_res[M], (ex_res == '0)};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                MUL: begin
                    prod <= prod_nxt;
                    b_q  <= b_q >> 1;
                    step <= step + CW'(1);
                    if (step == CW'(WIDTH - 1)) begin
                        result_q <= prod_nxt[M:0];
                        mul_hi_q <= prod_nxt[2*WIDTH-1:WIDTH];
                        flags_q  <= {1'b0, (prod_nxt[2*WIDTH-1:WIDTH] != '0),
                                     prod_nxt[M], (prod_nxt[M:0] == '0)};
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.busy      = busy_q;
    assign io.done      = done_q;
    assign io.result    = result_q;
    assign io.mul_hi    = mul_hi_q;
    assign io.flags     = flags_q;
    assign io.fsm_state = state;
endmodule
